// File: rtl/extra_table_ctrl_if.sv
// ----------------------------------------------------------------------------
// extra_table_ctrl_if
//
// Purpose: bundles the user-facing buses of the extra-table controller.
//          This covers the configuration write channel, the two lookup request
//          channels and the lookup response channel.
//
// Signals:
//   cfg_wr_valid/ready, cfg_wr_addr, cfg_wr_data : configuration write handshake
//   rd0_valid/ready, rd0_addr                    : lookup requester 0
//   rd1_valid/ready, rd1_addr                    : lookup requester 1
//   rsp_valid, rsp_id, rsp_data                  : lookup response (no backpressure)
//
// Modports:
//   master : table user side (drives requests, receives ready/response)
//   slave  : controller side
// ----------------------------------------------------------------------------
interface extra_table_ctrl_if #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 19
);
   logic                  cfg_wr_valid;
   logic                  cfg_wr_ready;
   logic [ADDR_WIDTH-1:0] cfg_wr_addr;
   logic [DATA_WIDTH-1:0] cfg_wr_data;

   logic                  rd0_valid;
   logic                  rd0_ready;
   logic [ADDR_WIDTH-1:0] rd0_addr;

   logic                  rd1_valid;
   logic                  rd1_ready;
   logic [ADDR_WIDTH-1:0] rd1_addr;

   logic                  rsp_valid;
   logic                  rsp_id;
   logic [DATA_WIDTH-1:0] rsp_data;

   modport master (
      output cfg_wr_valid, cfg_wr_addr, cfg_wr_data,
      output rd0_valid, rd0_addr,
      output rd1_valid, rd1_addr,
      input  cfg_wr_ready, rd0_ready, rd1_ready,
      input  rsp_valid, rsp_id, rsp_data
   );

   modport slave (
      input  cfg_wr_valid, cfg_wr_addr, cfg_wr_data,
      input  rd0_valid, rd0_addr,
      input  rd1_valid, rd1_addr,
      output cfg_wr_ready, rd0_ready, rd1_ready,
      output rsp_valid, rsp_id, rsp_data
   );
endinterface

// File: rtl/extra_table_ctrl.sv
// ----------------------------------------------------------------------------
// extra_table_ctrl
//
// Purpose: sole access controller for the extra-table simple dual-port RAM.
//          After reset, or when clear_req arrives while idle, it writes CLR_VAL
//          to every entry. In IDLE it forwards configuration writes to the RAM
//          write port. It also shares the RAM read port between two lookup
//          requesters using round-robin arbitration.
//
// Ports:
//   clk, rst        : single clock, asynchronous active-high reset
//   clear_req       : start a table clear (honoured in IDLE only)
//   busy            : high while starting up or clearing
//   clear_done      : one-cycle pulse in the first IDLE cycle after a clear
//   bus             : cfg write / lookup request / response channels
//   ram_wr_en/addr/data : RAM write port
//   ram_rd_addr     : RAM read address
//   ram_rd_data     : RAM read data, valid one cycle after ram_rd_addr
// ----------------------------------------------------------------------------
module extra_table_ctrl #(
   parameter int                    ADDR_WIDTH = 9,
   parameter int                    DATA_WIDTH = 19,
   parameter logic [DATA_WIDTH-1:0] CLR_VAL    = {DATA_WIDTH{1'b0}}
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear_req,
   output logic                  busy,
   output logic                  clear_done,
   extra_table_ctrl_if.slave     bus,
   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_CLEAR = 2'd1,
      ST_IDLE  = 2'd2
   } state_t;

   state_t                state_q,      state_d;
   logic [ADDR_WIDTH-1:0] clr_cnt_q,    clr_cnt_d;
   logic                  clear_done_q, clear_done_d;
   logic                  last_gnt_q,   last_gnt_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q,    rd_addr_d;
   logic                  rsp_valid_q,  rsp_valid_d;
   logic                  rsp_id_q,     rsp_id_d;
   logic                  byp_flag_q,   byp_flag_d;
   logic [DATA_WIDTH-1:0] byp_data_q,   byp_data_d;

   logic                  gnt_valid;
   logic                  gnt_id;
   logic [ADDR_WIDTH-1:0] gnt_addr;
   logic                  cfg_wr_fire;

   // ------------------------------------------------------------------------
   // Next-state, RAM port and handshake logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d          = state_q;
      clr_cnt_d        = clr_cnt_q;
      clear_done_d     = 1'b0;
      last_gnt_d       = last_gnt_q;
      rsp_id_d         = rsp_id_q;
      byp_data_d       = byp_data_q;

      ram_wr_en        = 1'b0;
      ram_wr_addr      = bus.cfg_wr_addr;
      ram_wr_data      = bus.cfg_wr_data;
      bus.cfg_wr_ready = 1'b0;
      gnt_valid        = 1'b0;
      gnt_id           = 1'b0;
      cfg_wr_fire      = 1'b0;

      case (state_q)
         ST_START: begin
            state_d = ST_CLEAR;
         end

         ST_CLEAR: begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = clr_cnt_q;
            ram_wr_data = CLR_VAL;
            // Counter is exactly ADDR_WIDTH bits, so it wraps to 0 by itself,
            // which leaves it ready for the next clear.
            clr_cnt_d   = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_ADDR) begin
               state_d      = ST_IDLE;
               clear_done_d = 1'b1;
            end
         end

         ST_IDLE: begin
            bus.cfg_wr_ready = 1'b1;
            cfg_wr_fire      = bus.cfg_wr_valid;
            ram_wr_en        = bus.cfg_wr_valid;
            if (clear_req) begin
               state_d = ST_CLEAR;
            end

            // Round robin: on contention the requester that did not win last
            // time is served; otherwise whoever is asking.
            gnt_valid = bus.rd0_valid | bus.rd1_valid;
            if (bus.rd0_valid && bus.rd1_valid) begin
               gnt_id = ~last_gnt_q;
            end else begin
               gnt_id = bus.rd1_valid;
            end
         end

         default: begin
            state_d = ST_START;
         end
      endcase

      gnt_addr      = gnt_id ? bus.rd1_addr : bus.rd0_addr;
      bus.rd0_ready = gnt_valid & ~gnt_id;
      bus.rd1_ready = gnt_valid &  gnt_id;

      // The read address is held between grants so the RAM output stays stable.
      ram_rd_addr   = gnt_valid ? gnt_addr : rd_addr_q;
      rd_addr_d     = ram_rd_addr;

      rsp_valid_d   = gnt_valid;
      // The RAM returns old data on a same-cycle write/read to one address,
      // so the write data is captured and substituted in the response.
      byp_flag_d    = gnt_valid & cfg_wr_fire & (bus.cfg_wr_addr == gnt_addr);
      if (gnt_valid) begin
         last_gnt_d = gnt_id;
         rsp_id_d   = gnt_id;
         byp_data_d = bus.cfg_wr_data;
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_START;
         clr_cnt_q    <= '0;
         clear_done_q <= 1'b0;
         last_gnt_q   <= 1'b1;
         rd_addr_q    <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         byp_flag_q   <= 1'b0;
         byp_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         clear_done_q <= clear_done_d;
         last_gnt_q   <= last_gnt_d;
         rd_addr_q    <= rd_addr_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         byp_flag_q   <= byp_flag_d;
         byp_data_q   <= byp_data_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign busy          = (state_q != ST_IDLE);
   assign clear_done    = clear_done_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = byp_flag_q ? byp_data_q : ram_rd_data;

endmodule

// File: tb/tb_extra_table_ctrl.sv
// ----------------------------------------------------------------------------
// tb_extra_table_ctrl
//
// Purpose: self-checking bench for extra_table_ctrl with a behavioural
//          512 x 19 RAM. Expected lookup responses come from a shadow copy
//          of the table and a round-robin reference. They are queued when a
//          request is driven and compared when rsp_valid appears.
// ----------------------------------------------------------------------------
module tb_extra_table_ctrl;

   localparam int AW    = 9;
   localparam int DW    = 19;
   localparam int DEPTH = 512;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clear_req = 1'b0;
   logic          busy;
   logic          clear_done;
   logic          ram_wr_en;
   logic [AW-1:0] ram_wr_addr;
   logic [DW-1:0] ram_wr_data;
   logic [AW-1:0] ram_rd_addr;
   logic [DW-1:0] ram_rd_data;

   extra_table_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

   extra_table_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .clear_req   (clear_req),
      .busy        (busy),
      .clear_done  (clear_done),
      .bus         (bus_if),
      .ram_wr_en   (ram_wr_en),
      .ram_wr_addr (ram_wr_addr),
      .ram_wr_data (ram_wr_data),
      .ram_rd_addr (ram_rd_addr),
      .ram_rd_data (ram_rd_data)
   );

   always #5 clk = ~clk;

   // Behavioural simple dual-port RAM: read-old-data on a same-address collision.
   logic [DW-1:0] ram_mem [DEPTH];
   always @(posedge clk) begin
      if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_wr_data;
      ram_rd_data <= ram_mem[ram_rd_addr];
   end

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   typedef struct {
      logic          id;
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;

   exp_t          sb_q[$];
   logic [DW-1:0] shadow [DEPTH];
   logic          exp_last = 1'b1;
   logic [AW-1:0] exp_rd_addr = '0;
   int            n_checks = 0;
   int            n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Response monitor
   always @(negedge clk) begin
      if (!rst && bus_if.rsp_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("rsp_unexpected", 32'(1), 32'(0));
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            $display("rsp  cyc=%0d id=%0d data=0x%05h (exp id=%0d data=0x%05h)",
                     cyc_cnt, bus_if.rsp_id, bus_if.rsp_data, e.id, e.data);
            check("rsp_id", 32'(bus_if.rsp_id), 32'(e.id));
            check("rsp_data", 32'(bus_if.rsp_data), 32'(e.data));
            check("rsp_latency", 32'(cyc_cnt), 32'(e.cyc));
         end
      end
   end

   task automatic zero_inputs();
      bus_if.cfg_wr_valid = 1'b0;
      bus_if.rd0_valid    = 1'b0;
      bus_if.rd1_valid    = 1'b0;
      clear_req           = 1'b0;
   endtask

   // One IDLE cycle of stimulus; entered and left at posedge+#1.
   task automatic drive(input logic cv, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                        input logic r0v, input logic [AW-1:0] r0a,
                        input logic r1v, input logic [AW-1:0] r1a, input logic clr);
      logic          gv;
      logic          gid;
      logic [AW-1:0] ga;
      exp_t          e;
      bus_if.cfg_wr_valid = cv;
      bus_if.cfg_wr_addr  = ca;
      bus_if.cfg_wr_data  = cd;
      bus_if.rd0_valid    = r0v;
      bus_if.rd0_addr     = r0a;
      bus_if.rd1_valid    = r1v;
      bus_if.rd1_addr     = r1a;
      clear_req           = clr;
      #1;
      gv  = r0v | r1v;
      gid = (r0v && r1v) ? ~exp_last : (r0v ? 1'b0 : 1'b1);
      ga  = gid ? r1a : r0a;
      check("cfg_wr_ready", 32'(bus_if.cfg_wr_ready), 32'(1));
      check("rd0_ready", 32'(bus_if.rd0_ready), 32'(gv && !gid));
      check("rd1_ready", 32'(bus_if.rd1_ready), 32'(gv && gid));
      check("ram_wr_en", 32'(ram_wr_en), 32'(cv));
      if (cv) begin
         check("ram_wr_addr", 32'(ram_wr_addr), 32'(ca));
         check("ram_wr_data", 32'(ram_wr_data), 32'(cd));
      end
      check("ram_rd_addr", 32'(ram_rd_addr), 32'(gv ? ga : exp_rd_addr));
      $display("req  cyc=%0d cfg=%0d@0x%03h=0x%05h rd0=%0d@0x%03h rd1=%0d@0x%03h clr=%0d gnt=%0d/%0d",
               cyc_cnt, cv, ca, cd, r0v, r0a, r1v, r1a, clr, gv, gid);
      if (gv) begin
         e.id   = gid;
         e.data = (cv && ca == ga) ? cd : shadow[ga];
         e.cyc  = cyc_cnt + 1;
         sb_q.push_back(e);
         exp_last    = gid;
         exp_rd_addr = ga;
      end
      if (cv) shadow[ca] = cd;
      @(posedge clk);
      #1;
      zero_inputs();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'(1));
      check({tag, "_clear_done"}, 32'(clear_done), 32'(0));
      check({tag, "_rsp_valid"}, 32'(bus_if.rsp_valid), 32'(0));
      check({tag, "_rsp_id"}, 32'(bus_if.rsp_id), 32'(0));
      check({tag, "_wr_en"}, 32'(ram_wr_en), 32'(0));
      check({tag, "_ready"}, 32'({bus_if.cfg_wr_ready, bus_if.rd0_ready, bus_if.rd1_ready}), 32'(0));
      check({tag, "_rd_addr"}, 32'(ram_rd_addr), 32'(0));
   endtask

   // Watches a full clear. Requests and a repeated clear_req are held high
   // throughout; none may be accepted or restart the sweep.
   task automatic check_clear(input string tag);
      int n = 0;
      int bad = 0;
      int rdy = 0;
      int guard = 0;
      bus_if.cfg_wr_valid = 1'b1;
      bus_if.cfg_wr_addr  = 9'h155;
      bus_if.cfg_wr_data  = 19'h12345;
      bus_if.rd0_valid    = 1'b1;
      bus_if.rd0_addr     = 9'h0AA;
      bus_if.rd1_valid    = 1'b1;
      bus_if.rd1_addr     = 9'h0BB;
      clear_req           = 1'b1;
      @(negedge clk);
      while (busy && guard < 2000) begin
         if (ram_wr_en) begin
            if (ram_wr_addr !== n[AW-1:0] || ram_wr_data !== '0) bad++;
            n++;
         end
         if (bus_if.cfg_wr_ready || bus_if.rd0_ready || bus_if.rd1_ready) rdy++;
         if (clear_done) bad++;
         guard++;
         @(negedge clk);
      end
      zero_inputs();
      $display("clr  %s cyc=%0d writes=%0d bad=%0d ready_seen=%0d", tag, cyc_cnt, n, bad, rdy);
      check({tag, "_finished"}, 32'(busy), 32'(0));
      check({tag, "_writes"}, 32'(n), 32'(DEPTH));
      check({tag, "_bad_write"}, 32'(bad), 32'(0));
      check({tag, "_ready_low"}, 32'(rdy), 32'(0));
      check({tag, "_done"}, 32'(clear_done), 32'(1));
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, 32'(clear_done), 32'(0));
      for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      zero_inputs();
      bus_if.cfg_wr_addr = '0;
      bus_if.cfg_wr_data = '0;
      bus_if.rd0_addr    = '0;
      bus_if.rd1_addr    = '0;
      for (int i = 0; i < DEPTH; i++) shadow[i] = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      rst = 1'b0;
      check_clear("init_clear");

      // Write then lookup through requester 0
      drive(1, 9'h1F3, 19'h5A5A5, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 9'h1F3, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);

      // Preload, then contention for four cycles (rd1 served last, so 0,1,0,1)
      for (int i = 0; i < 4; i++) drive(1, 9'(9'h020 + i), 19'(19'h01000 + i), 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 9'h020, 0);
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 9'(9'h020 + i), 1, 9'(9'h023 - i), 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);

      // Same-cycle write and lookup of one address: new value forwarded
      drive(1, 9'h010, 19'h00ABC, 0, 0, 0, 0, 0);
      drive(1, 9'h010, 19'h7FFFF, 0, 0, 1, 9'h010, 0);
      drive(0, 0, 0, 1, 9'h010, 0, 0, 0);

      // Mixed back-to-back traffic over a small address window
      for (int i = 0; i < 12; i++) begin
         drive(1'($urandom_range(0, 1)), 9'(9'h040 + $urandom_range(0, 3)), 19'($urandom),
               1'($urandom_range(0, 1)), 9'(9'h040 + $urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 9'(9'h040 + $urandom_range(0, 3)), 0);
      end

      // clear_req together with a cfg write and a rd0 grant
      drive(1, 9'h1F3, 19'h11111, 1, 9'h1F3, 0, 0, 1);
      check_clear("req_clear");
      drive(0, 0, 0, 0, 0, 1, 9'h1F3, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);

      // Reset pulsed mid-clear at clear address 200
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      guard = 0;
      @(negedge clk);
      while (!(ram_wr_en && ram_wr_addr == 9'd200) && guard < 1000) begin
         guard++;
         @(negedge clk);
      end
      check("midclear_reached", 32'(ram_wr_addr), 32'(200));
      #1;
      rst = 1'b1;
      #1;
      check_reset_vals("midclear_rst");
      exp_last    = 1'b1;
      exp_rd_addr = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_clear("rst_clear");

      // Round robin restarts with requester 0; table reads back cleared
      drive(1, 9'h0AA, 19'h2468A, 1, 9'h010, 1, 9'h0AA, 0);
      drive(0, 0, 0, 1, 9'h0AA, 1, 9'h1F3, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);

      check("sb_drained", 32'(sb_q.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/extra_table_ctrl.md
# extra_table_ctrl

Single-clock access controller for the 512 x 19 extra-table simple dual-port RAM. After reset, and on request, it clears every table entry. It then accepts configuration writes on the RAM write port and shares the RAM read port between two lookup requesters using round-robin arbitration. It sits between the table RAM and its users and is the only block that drives the RAM address, data and enable pins.

## Interface
Parameters:
- ADDR_WIDTH, 9, table address width; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 19, table entry width.
- CLR_VAL, {DATA_WIDTH{1'b0}}, value written to every entry during clear.

Ports:
- clk, input, 1, the single clock; drives both RAM clocks.
- rst, input, 1, asynchronous active-high reset; also drives the RAM wr_rst/rd_rst.
- clear_req, input, 1, start a table clear (honoured in IDLE only).
- busy, output, 1, high in START and CLEAR.
- clear_done, output, 1, one-cycle pulse in the first IDLE cycle after a clear.
- cfg_wr_valid / cfg_wr_ready, input / output, 1 / 1, configuration write handshake.
- cfg_wr_addr, input, ADDR_WIDTH, configuration write address.
- cfg_wr_data, input, DATA_WIDTH, configuration write data.
- rd0_valid / rd0_ready, input / output, 1 / 1, requester 0 lookup handshake.
- rd0_addr, input, ADDR_WIDTH, requester 0 lookup address.
- rd1_valid / rd1_ready / rd1_addr, as for requester 0.
- rsp_valid, output, 1, lookup response valid.
- rsp_id, output, 1, requester that owns the response (0 or 1).
- rsp_data, output, DATA_WIDTH, lookup data.
- ram_wr_en, output, 1, RAM write enable.
- ram_wr_addr, output, ADDR_WIDTH, RAM write address.
- ram_wr_data, output, DATA_WIDTH, RAM write data.
- ram_rd_addr, output, ADDR_WIDTH, RAM read address.
- ram_rd_data, input, DATA_WIDTH, RAM read data; valid one cycle after the address.

## Operation
- States: START, CLEAR, IDLE. Reset enters START.
- START lasts one cycle, then moves to CLEAR.
- CLEAR:
  - ram_wr_en=1, ram_wr_addr=clr_cnt, ram_wr_data=CLR_VAL.
  - clr_cnt counts 0..DEPTH-1. At clr_cnt==DEPTH-1 the next state is IDLE and clr_cnt wraps to 0.
  - All ready signals are 0.
- IDLE:
  - cfg_wr_ready=1. On cfg_wr_valid, ram_wr_en=1 and addr/data are passed through combinationally.
  - clear_req in IDLE moves the state to CLEAR next cycle. A cfg write accepted in that same cycle still happens, and the clear then overwrites it.
  - clear_req in START or CLEAR is ignored; the clear is not restarted.
- Read arbitration (IDLE only):
  - Register last_gnt resets to 1.
  - One valid requester: it is granted.
  - Both valid: the requester != last_gnt is granted.
  - rdN_ready is high only for the granted requester. last_gnt updates only on a grant.
  - ram_rd_addr = granted address, otherwise holds its previous value.
- Response:
  - rsp_valid, rsp_id, and the bypass flag/data are registered at the grant edge.
  - rsp_data is combinational: bypass data if the flag is set, else ram_rd_data.
- Write/read collision: if a cfg write and a read grant in the same cycle use the same address, the RAM returns the old data. The controller therefore forwards cfg_wr_data, so the response carries the new value.
- A grant in the last IDLE cycle before CLEAR still produces its response.

## Timing
- Reset values: busy=1; clear_done, rsp_valid, rsp_id, ram_wr_en, all ready signals = 0; ram_rd_addr=0; rsp_data undefined.
- From the first clk edge after rst falls:
  - Edge 1 leaves START.
  - Edges 2..DEPTH+1 perform the clear writes (512 writes).
  - IDLE begins after edge DEPTH+1. clear_done=1 and busy=0 in that first IDLE cycle.
- Lookup latency: grant in cycle N gives rsp_valid=1 in cycle N+1, for exactly one cycle per grant.
- Throughput: one lookup per cycle total, plus one concurrent cfg write per cycle.
- No backpressure on responses; consumers must accept rsp_valid unconditionally.
- rst asserted at any time aborts an in-progress clear or response. The full clear reruns after release.

## Test plan
- Reset release: 512 consecutive ram_wr_en cycles with addresses 0..511 and data 0 -> then busy=0 with a single-cycle clear_done; all ready signals low until then.
- Write 0x5A5A5 to addr 0x1F3, then rd0 lookup of 0x1F3 -> rsp_valid one cycle later, rsp_id=0, rsp_data=0x5A5A5.
- rd0 and rd1 both valid for 4 cycles -> grant order 0,1,0,1; responses alternate rsp_id 0,1,0,1.
- Same-cycle cfg write 0x7FFFF to addr 0x010 and rd1 grant at 0x010 -> response data 0x7FFFF, not the old value.
- clear_req while a cfg write and a rd0 grant occur -> rd0 response delivered; then 512 clear cycles; a subsequent lookup returns 0.
- rst pulsed mid-clear at clr_cnt=200 -> outputs go to reset values immediately; after release the clear restarts at address 0 and runs a full 512 cycles.
